// File: rtl/vga_scan_out.sv
// VGA scan-out: pixel/line counters, sync decode and one registered pin stage
// that blanks the RGB332 byte outside the visible area.
module vga_scan_out #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_ce,
    input  logic [7:0] rgb,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       active,
    output logic       frame_start,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [1:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs
);

    localparam int unsigned CW       = 10;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          fs_q, fs_d;
    logic [7:0]    rgb_q, rgb_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;

    logic          x_last_c, y_last_c;
    logic          active_c, hs_raw_c, vs_raw_c;

    assign x_last_c = (x_q == CW'(H_TOTAL - 1));
    assign y_last_c = (y_q == CW'(V_TOTAL - 1));
    assign active_c = (x_q < CW'(H_ACTIVE)) && (y_q < CW'(V_ACTIVE));
    assign hs_raw_c = (x_q >= CW'(HS_START)) && (x_q < CW'(HS_END));
    assign vs_raw_c = (y_q >= CW'(VS_START)) && (y_q < CW'(VS_END));

    // Counter advance and pin-stage load, both gated by the pixel enable
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        fs_d  = 1'b0;
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (pix_ce) begin
            if (x_last_c) begin
                x_d  = '0;
                y_d  = y_last_c ? '0 : y_q + CW'(1);
                fs_d = y_last_c;
            end else begin
                x_d = x_q + CW'(1);
            end
            rgb_d = active_c ? rgb : 8'h00;
            hs_d  = hs_raw_c ? SYNC_POL : ~SYNC_POL;
            vs_d  = vs_raw_c ? SYNC_POL : ~SYNC_POL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            fs_q  <= 1'b0;
            rgb_q <= 8'h00;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            fs_q  <= fs_d;
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign active      = active_c;
    assign frame_start = fs_q;
    assign vga_r       = rgb_q[7:5];
    assign vga_g       = rgb_q[4:2];
    assign vga_b       = rgb_q[1:0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: a default-timing instance and a miniature-timing
// instance share stimulus; both are compared against a pixel-tick count model.
module tb_vga_scan_out;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_ce;
    logic [7:0] rgb;

    logic [9:0] d_x, d_y, s_x, s_y;
    logic       d_act, d_fs, d_hs, d_vs, s_act, s_fs, s_hs, s_vs;
    logic [2:0] d_r, d_g, s_r, s_g;
    logic [1:0] d_b, s_b;

    always #5 clk = ~clk;

    vga_scan_out u_def (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .rgb(rgb),
        .pixel_x(d_x), .pixel_y(d_y), .active(d_act), .frame_start(d_fs),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .vga_hs(d_hs), .vga_vs(d_vs)
    );

    // Miniature frame: 25 ticks per line, 11 lines, so whole frames fit the run
    vga_scan_out #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
    ) u_sml (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .rgb(rgb),
        .pixel_x(s_x), .pixel_y(s_y), .active(s_act), .frame_start(s_fs),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs)
    );

    int checks   = 0;
    int failures = 0;

    // Model: pixel ticks since reset release, last sampled byte, last edge kind
    int         n       = 0;
    logic [7:0] last_rgb = 8'h00;
    bit         ce_edge = 1'b0;

    int hs_cnt_d = 0, hs_first_d = 0, hs_cnt_s = 0, hs_first_s = 0;
    int fs_cnt_s = 0;

    typedef struct {
        bit         ce;
        logic [7:0] rgb;
        int         ex;
        logic [7:0] epins;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (tick %0d)", nm, a, e, n);
        end
    endtask

    // Compare one instance with the tick-count model for the given timing
    task automatic check_inst(input string tag,
                              input int ha, input int hf, input int hsw, input int hb,
                              input int va, input int vf, input int vsw, input int vb,
                              input logic [9:0] x, input logic [9:0] y,
                              input logic act, input logic fs,
                              input logic [7:0] pins, input logic hs, input logic vs);
        int ht, vt, ex, ey, px, py;
        logic [7:0] ep;
        logic ehs, evs;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        ex = n % ht;
        ey = (n / ht) % vt;
        ep = 8'h00; ehs = 1'b1; evs = 1'b1;
        if (n > 0) begin
            px  = (n - 1) % ht;
            py  = ((n - 1) / ht) % vt;
            ep  = (px < ha && py < va) ? last_rgb : 8'h00;
            ehs = !(px >= ha + hf && px < ha + hf + hsw);
            evs = !(py >= va + vf && py < va + vf + vsw);
        end
        chk({tag, ".x"}, 32'(x), 32'(ex));
        chk({tag, ".y"}, 32'(y), 32'(ey));
        chk({tag, ".active"}, 32'(act), 32'(ex < ha && ey < va));
        chk({tag, ".frame_start"}, 32'(fs), 32'(ce_edge && n > 0 && (n % (ht * vt)) == 0));
        chk({tag, ".pins"}, 32'(pins), 32'(ep));
        chk({tag, ".hs"}, 32'(hs), 32'(ehs));
        chk({tag, ".vs"}, 32'(vs), 32'(evs));
    endtask

    task automatic check_all();
        check_inst("def", 640, 16, 96, 48, 480, 10, 2, 33,
                   d_x, d_y, d_act, d_fs, {d_r, d_g, d_b}, d_hs, d_vs);
        check_inst("sml", 16, 2, 4, 3, 6, 1, 2, 2,
                   s_x, s_y, s_act, s_fs, {s_r, s_g, s_b}, s_hs, s_vs);
    endtask

    // One clk: drive at negedge, update model on the edge, sample at next negedge
    task automatic step(input bit ce, input logic [7:0] v);
        pix_ce = ce;
        rgb    = v;
        @(posedge clk);
        if (ce) begin
            n++;
            last_rgb = v;
        end
        ce_edge = ce;
        @(negedge clk);
        if (ce && n >= 1 && n <= 800 && d_hs == 1'b0) begin
            hs_cnt_d++;
            if (hs_first_d == 0) hs_first_d = n;
        end
        if (ce && n >= 1 && n <= 25 && s_hs == 1'b0) begin
            hs_cnt_s++;
            if (hs_first_s == 0) hs_first_s = n;
        end
        if (s_fs) fs_cnt_s++;
        check_all();
    endtask

    task automatic check_reset_pins(input string tag);
        chk({tag, ".def_xy"}, 32'({d_x, d_y}), 32'(0));
        chk({tag, ".def_pins"}, 32'({d_r, d_g, d_b, d_hs, d_vs, d_fs, d_act}), 32'(11'b00000000_11_0_1));
        chk({tag, ".sml_xy"}, 32'({s_x, s_y}), 32'(0));
        chk({tag, ".sml_pins"}, 32'({s_r, s_g, s_b, s_hs, s_vs, s_fs, s_act}), 32'(11'b00000000_11_0_1));
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 8'hFF, 1, 8'hFF};
        vecs[1] = '{1'b0, 8'h00, 1, 8'hFF};
        vecs[2] = '{1'b1, 8'hE0, 2, 8'hE0};
        vecs[3] = '{1'b1, 8'h1C, 3, 8'h1C};
        vecs[4] = '{1'b0, 8'h03, 3, 8'h1C};
        vecs[5] = '{1'b1, 8'h03, 4, 8'h03};

        rst_n = 1'b0; pix_ce = 1'b1; rgb = 8'hFF;
        repeat (3) @(negedge clk);
        check_reset_pins("reset");
        rst_n = 1'b1;
        n = 0; ce_edge = 1'b0;

        // Table: first ticks after release, including held cycles
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].ce, vecs[i].rgb);
            chk("tbl.def_x", 32'(d_x), 32'(vecs[i].ex));
            chk("tbl.def_pins", 32'({d_r, d_g, d_b, d_hs, d_vs}), 32'({vecs[i].epins, 2'b11}));
            chk("tbl.sml_pins", 32'({s_r, s_g, s_b, s_hs, s_vs}), 32'({vecs[i].epins, 2'b11}));
        end

        // Finish the first default line with a constant white byte
        while (n < 800) step(1'b1, 8'hFF);
        chk("hs_len_def", 32'(hs_cnt_d), 32'(96));
        chk("hs_first_def", 32'(hs_first_d), 32'(657));
        chk("hs_len_sml", 32'(hs_cnt_s), 32'(4));
        chk("hs_first_sml", 32'(hs_first_s), 32'(19));

        // Spaceship red in the visible area, a stray byte in the blanking
        while (n < 1600) step(1'b1, ((n % 800) == 700) ? 8'h1C : 8'hE0);

        // Random enables and bytes over several miniature frames
        while (n < 2600) step(1'($urandom_range(0, 1)), 8'($urandom));
        chk("fs_count_sml", 32'(fs_cnt_s), 32'(n / 275));

        // Asynchronous reset partway through a line
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_pins("async_rst");
        pix_ce = 1'b1;
        @(negedge clk);
        check_reset_pins("held_rst");
        rst_n = 1'b1;
        n = 0; ce_edge = 1'b0; fs_cnt_s = 0;
        step(1'b1, 8'h5A);
        chk("post_rst_x", 32'(d_x), 32'(1));
        while (n < 600) step(1'($urandom_range(0, 1)), 8'($urandom));
        chk("fs_count_post_rst", 32'(fs_cnt_s), 32'(n / 275));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scan_out.md
Name: vga_scan_out

Overview:
- Display-side consumer of the 8-bit RGB332 pixel byte produced by the colour-code-to-RGB mapper.
- Generates VGA horizontal/vertical timing and publishes the current pixel coordinate to the renderer.
- Samples the returned rgb byte, blanks it outside the active area, and drives registered R/G/B and sync pins with all outputs aligned.
- Sits between the game renderer / colour mapper and the board's VGA connector.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch in lines
- SYNC_POL, 0, asserted sync level (0 = active-low)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_ce  in  1  pixel-rate enable; all counters and output registers advance only when high
- rgb  in  8  RGB332 byte {R[7:5],G[4:2],B[1:0]} for the coordinate currently on pixel_x/pixel_y, valid in the same cycle (combinational return path)
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1
- active  out  1  high when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
- frame_start  out  1  one-clk pulse on the pix_ce cycle where the counters wrap to (0,0)
- vga_r  out  3  red pins
- vga_g  out  3  green pins
- vga_b  out  2  blue pins
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync

Behaviour:
- Timing totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset values: pixel_x=0, pixel_y=0, frame_start=0, vga_r/g/b=0, vga_hs=vga_vs=~SYNC_POL (deasserted). active follows the counters combinationally, so it is 1 during reset.
- Counter update:
  - Occurs only on clk edges with pix_ce=1.
  - pixel_x increments; at H_TOTAL-1 it wraps to 0 and pixel_y increments.
  - pixel_y wraps from V_TOTAL-1 to 0 only on the same edge where pixel_x wraps.
- Sync decode, combinational from the counters:
  - hs_raw is asserted for pixel_x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs_raw is asserted for pixel_y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - Asserted level = SYNC_POL.
- Output stage: one register stage, loaded on pix_ce.
  - vga_r/g/b <= active ? rgb fields : 0.
  - vga_hs/vga_vs <= hs_raw/vs_raw.
  - Pin latency is therefore exactly one pixel tick after coordinate (x,y) is presented; sync and colour are always mutually aligned.
- frame_start:
  - Asserted for exactly one clk, on the edge where the counters move from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Zero in every other cycle, including pix_ce=0 cycles.
- pix_ce=0: all state holds. frame_start=0. Outputs are unchanged.
- pix_ce tied high is legal (clk is then the pixel clock).
- Blanking is absolute: rgb is ignored whenever active=0, whatever its value.
- Reset asserted mid-line: all registers return to reset values immediately (asynchronous). After release, the first pix_ce edge moves the counters to (1,0).
- Counter width is 10 bits. The totals with default parameters must be ≤ 1024; larger totals are unsupported.

Test Plan:
- Reset release, pix_ce=1, rgb=8'hFF constant → vga_r=7, vga_g=7, vga_b=3 from the edge after (0,0) through the edge after (639,y); zero during x=640..799.
- Horizontal sync → vga_hs low for exactly 96 consecutive pix_ce ticks. Its first low pin cycle is registered from x=656; line period is 800 ticks.
- Vertical sync → vga_vs low for exactly 2×800 ticks starting at y=490. Frame period is 420000 ticks. frame_start pulses once per frame at the wrap to (0,0).
- pix_ce toggling every other clk → pin waveforms identical to the pix_ce=1 case in ticks, each stretched to 2 clks. Counters never advance on pix_ce=0 cycles.
- rgb=8'hE0 (spaceship colour) during active, 8'h1C at x=700 → pins show R=7, G=0, B=0 in active; 0 at x=700 (blanked).
- rst_n pulsed low at (320,100) → pins go to 0/deasserted sync asynchronously, counters read (0,0). Normal scan resumes after release with no spurious frame_start.
